// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: register-file addressing, WB bypass, load-use stall,
// branch flush and a saturating stall counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_id_instr,
  input  logic [7:0]        ctl_in,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_w_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic              stall,
  output logic [7:0]        ex_ctl,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned MEM_RD  = 2;

  logic [REG_W-1:0]  rd;
  logic [31:0]       imm;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              hazard;
  logic              unused_opcode;

  // Opcode is decoded upstream into ctl_in.
  assign unused_opcode = ^if_id_instr[31:26];

  assign rs_addr = if_id_instr[25:21];
  assign rt_addr = if_id_instr[20:16];
  assign rd      = if_id_instr[15:11];
  assign imm     = {{(32 - IMM_W){if_id_instr[IMM_W-1]}}, if_id_instr[IMM_W-1:0]};

  // Writeback bypass; $0 is hardwired and never forwarded.
  always_comb begin
    op1 = rf_data1;
    op2 = rf_data2;
    if (wb_reg_write && (wb_w_reg != '0) && (wb_w_reg == rs_addr)) op1 = wb_data;
    if (wb_reg_write && (wb_w_reg != '0) && (wb_w_reg == rt_addr)) op2 = wb_data;
  end

  // rt is compared even for I-type consumers; a spurious bubble is harmless.
  always_comb begin
    hazard = ex_ctl[MEM_RD] && (ex_rt != '0) && ((ex_rt == rs_addr) || (ex_rt == rt_addr));
    stall  = hazard && !flush && rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush || stall) begin
      ex_ctl   <= '0;
      ex_data1 <= '0;
      ex_data2 <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
    end else begin
      ex_ctl   <= ctl_in;
      ex_data1 <= op1;
      ex_data2 <= op2;
      ex_imm   <= imm;
      ex_rs    <= rs_addr;
      ex_rt    <= rt_addr;
      ex_rd    <= rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed plan items followed by
// randomized traffic against a slot-level reference model.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic [7:0]  ctl_in;
  logic [31:0] rf_data1, rf_data2, wb_data;
  logic        wb_reg_write, flush;
  logic [4:0]  wb_w_reg;

  logic [4:0]  rs_addr, rt_addr, ex_rs, ex_rt, ex_rd;
  logic        stall;
  logic [7:0]  ex_ctl;
  logic [31:0] ex_data1, ex_data2, ex_imm;
  logic [15:0] stall_count;

  logic [4:0]  s_rs_addr, s_rt_addr, s_ex_rs, s_ex_rt, s_ex_rd;
  logic        s_stall;
  logic [7:0]  s_ex_ctl;
  logic [31:0] s_ex_data1, s_ex_data2, s_ex_imm;
  logic [3:0]  s_stall_count;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .ctl_in(ctl_in),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_reg_write(wb_reg_write),
    .wb_w_reg(wb_w_reg), .wb_data(wb_data), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .stall(stall), .ex_ctl(ex_ctl),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .ctl_in(ctl_in),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_reg_write(wb_reg_write),
    .wb_w_reg(wb_w_reg), .wb_data(wb_data), .flush(flush),
    .rs_addr(s_rs_addr), .rt_addr(s_rt_addr), .stall(s_stall), .ex_ctl(s_ex_ctl),
    .ex_data1(s_ex_data1), .ex_data2(s_ex_data2), .ex_imm(s_ex_imm),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the instruction occupying EX, a bubble being an all-zero slot.
  typedef struct packed {
    logic [7:0]  ctl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } slot_t;

  slot_t m_ex;
  int    m_cnt;
  int    m_cnt_sat;
  int    n_tests;
  int    n_fail;
  logic  last_stall;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_cycle(input logic [31:0] i_instr, input logic [7:0] i_ctl,
                           input logic [31:0] i_rf1, input logic [31:0] i_rf2,
                           input logic i_wbwe, input logic [4:0] i_wbreg,
                           input logic [31:0] i_wbdat, input logic i_flush,
                           input logic i_rstn);
    logic [4:0] rs, rt;
    logic       load_in_ex, dep, exp_stall;
    slot_t      nxt;
    if_id_instr  = i_instr;
    ctl_in       = i_ctl;
    rf_data1     = i_rf1;
    rf_data2     = i_rf2;
    wb_reg_write = i_wbwe;
    wb_w_reg     = i_wbreg;
    wb_data      = i_wbdat;
    flush        = i_flush;
    rst_n        = i_rstn;

    rs = i_instr[25:21];
    rt = i_instr[20:16];
    nxt.ctl = i_ctl;
    nxt.d1  = (i_wbwe && i_wbreg != 0 && i_wbreg == rs) ? i_wbdat : i_rf1;
    nxt.d2  = (i_wbwe && i_wbreg != 0 && i_wbreg == rt) ? i_wbdat : i_rf2;
    nxt.imm = 32'(signed'(i_instr[15:0]));
    nxt.rs  = rs;
    nxt.rt  = rt;
    nxt.rd  = i_instr[15:11];

    load_in_ex = m_ex.ctl[2] && m_ex.rt != 0;
    dep        = (m_ex.rt == rs) || (m_ex.rt == rt);
    exp_stall  = load_in_ex && dep && !i_flush && i_rstn;

    #1;
    check_eq("rs_addr", 64'(rs_addr), 64'(rs));
    check_eq("rt_addr", 64'(rt_addr), 64'(rt));
    check_eq("stall", 64'(stall), 64'(exp_stall));
    check_eq("stall_sat", 64'(s_stall), 64'(exp_stall));
    last_stall = stall;

    if (!i_rstn) begin
      m_ex      = '0;
      m_cnt     = 0;
      m_cnt_sat = 0;
    end else if (i_flush || exp_stall) begin
      m_ex = '0;
      if (exp_stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_sat < 15) m_cnt_sat++;
      end
    end else begin
      m_ex = nxt;
    end

    @(posedge clk);
    #1;
    check_eq("ex_ctl", 64'(ex_ctl), 64'(m_ex.ctl));
    check_eq("ex_data1", 64'(ex_data1), 64'(m_ex.d1));
    check_eq("ex_data2", 64'(ex_data2), 64'(m_ex.d2));
    check_eq("ex_imm", 64'(ex_imm), 64'(m_ex.imm));
    check_eq("ex_rs", 64'(ex_rs), 64'(m_ex.rs));
    check_eq("ex_rt", 64'(ex_rt), 64'(m_ex.rt));
    check_eq("ex_rd", 64'(ex_rd), 64'(m_ex.rd));
    check_eq("stall_count", 64'(stall_count), 64'(m_cnt));
    check_eq("stall_count_sat", 64'(s_stall_count), 64'(m_cnt_sat));
  endtask

  localparam logic [31:0] ADD_8_9_10 = 32'h012A4020;
  localparam logic [31:0] LW_8_M4_9  = 32'h8D28FFFC;
  localparam logic [31:0] ADD_10_8_8 = 32'h01085020;
  localparam logic [31:0] LW_8_0_8   = 32'h8D080000;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ex    = '0;
    m_cnt   = 0;
    m_cnt_sat = 0;
    last_stall = 1'b0;

    // Reset with everything driven high.
    repeat (2) run_cycle(32'hFFFFFFFF, 8'hFF, 32'h1, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check_eq("rst_stall", 64'(last_stall), 64'd0);
    check_eq("rst_ex_ctl", 64'(ex_ctl), 64'd0);
    check_eq("rst_ex_imm", 64'(ex_imm), 64'd0);
    check_eq("rst_count", 64'(stall_count), 64'd0);

    // Normal latch of an R-type add.
    run_cycle(ADD_8_9_10, 8'h21, 32'd5, 32'd7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_eq("add_ex_rs", 64'(ex_rs), 64'd9);
    check_eq("add_ex_rt", 64'(ex_rt), 64'd10);
    check_eq("add_ex_rd", 64'(ex_rd), 64'd8);
    check_eq("add_ex_d1", 64'(ex_data1), 64'd5);
    check_eq("add_ex_d2", 64'(ex_data2), 64'd7);
    check_eq("add_ex_imm", 64'(ex_imm), 64'h00004020);
    check_eq("add_ex_ctl", 64'(ex_ctl), 64'h21);

    // Load-use: one bubble, then the dependent add enters EX.
    run_cycle(LW_8_M4_9, 8'h17, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_eq("lw_ex_imm", 64'(ex_imm), 64'hFFFFFFFC);
    run_cycle(ADD_10_8_8, 8'h21, 32'h3, 32'h3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_eq("lu_stall", 64'(last_stall), 64'd1);
    check_eq("lu_bubble", 64'(ex_ctl), 64'd0);
    run_cycle(ADD_10_8_8, 8'h21, 32'h3, 32'h3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_eq("lu_release", 64'(last_stall), 64'd0);
    check_eq("lu_add_ctl", 64'(ex_ctl), 64'h21);
    check_eq("lu_count", 64'(stall_count), 64'd1);

    // Bypass from writeback, and $0 never bypassed.
    run_cycle(ADD_8_9_10, 8'h21, 32'h11, 32'h22, 1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 1'b1);
    check_eq("byp_d1", 64'(ex_data1), 64'hDEADBEEF);
    run_cycle(32'h000A4020, 8'h21, 32'h11, 32'h22, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b1);
    check_eq("byp_zero_d1", 64'(ex_data1), 64'h11);

    // Flush during a load-use hazard.
    run_cycle(LW_8_M4_9, 8'h17, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    run_cycle(ADD_10_8_8, 8'h21, 32'h3, 32'h3, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    check_eq("fl_stall", 64'(last_stall), 64'd0);
    check_eq("fl_ex_ctl", 64'(ex_ctl), 64'd0);
    check_eq("fl_count", 64'(stall_count), 64'd1);

    // Back-to-back self-dependent loads: a stall every other cycle.
    repeat (40) run_cycle(LW_8_0_8, 8'h04, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check_eq("sat_count4", 64'(s_stall_count), 64'd15);
    check_eq("sat_count16", 64'(stall_count), 64'd21);

    // Random traffic over a small register set to provoke hazards and bypasses.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = {6'($urandom), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
             5'($urandom), 11'($urandom)};
      run_cycle(ins, 8'($urandom), $urandom, $urandom, 1'($urandom),
                5'($urandom_range(3, 0)), $urandom,
                ($urandom_range(7, 0) == 0), ($urandom_range(39, 0) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Drives the register file read addresses from the IF/ID instruction, then captures the read data, sign-extended immediate, register specifiers and control bundle into the ID/EX pipeline register.
- Provides WB-to-ID bypass (covers same-cycle writeback), load-use hazard detection with single-bubble stall, branch flush, and a saturating stall counter.

Parameters:
DATA_W, 32, datapath width
CNT_W, 16, stall_count width

Ports:
clk  input  1  pipeline clock; stage register updates on posedge
rst_n  input  1  synchronous active-low reset
if_id_instr  input  32  instruction from IF/ID register
ctl_in  input  8  control bundle: [0]reg_write [1]mem_to_reg [2]mem_read [3]mem_write [4]alu_src [5]reg_dst [7:6]alu_op
rf_data1  input  DATA_W  register file read port 1 data
rf_data2  input  DATA_W  register file read port 2 data
wb_reg_write  input  1  writeback write enable
wb_w_reg  input  5  writeback destination
wb_data  input  DATA_W  writeback data
flush  input  1  branch taken; squash instruction entering EX
rs_addr  output  5  to register file reg1 (combinational)
rt_addr  output  5  to register file reg2 (combinational)
stall  output  1  hold PC and IF/ID (combinational)
ex_ctl  output  8  registered control bundle
ex_data1  output  DATA_W  registered operand 1
ex_data2  output  DATA_W  registered operand 2
ex_imm  output  32  registered sign-extended immediate
ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Field extraction:
  - rs_addr = instr[25:21], rt_addr = instr[20:16], rd = instr[15:11].
  - imm = {16{instr[15]}, instr[15:0]}.
- Bypass (combinational):
  - op1 = wb_data if wb_reg_write && wb_w_reg != 0 && wb_w_reg == rs_addr; else rf_data1.
  - op2 likewise against rt_addr with rf_data2.
  - Register $0 is never bypassed.
- Hazard (combinational):
  - hazard = ex_ctl[2] && ex_rt != 0 && (ex_rt == rs_addr || ex_rt == rt_addr).
  - rt is compared conservatively regardless of instruction format.
  - stall = hazard && !flush && rst_n.
- Stage register, posedge clk, priority reset > flush > stall > normal:
  - rst_n=0: all ex_* outputs 0, stall_count 0.
  - flush=1: bubble. ex_ctl=0 and all other ex_* outputs 0.
  - stall=1: bubble, same as flush. IF/ID is held by upstream, so the same instruction is re-presented next cycle.
  - Otherwise: ex_ctl←ctl_in, ex_data1←op1, ex_data2←op2, ex_imm←imm, ex_rs/ex_rt/ex_rd←fields.
- Latency:
  - One cycle from if_id_instr to ex_* outputs.
  - A load-use hazard costs exactly one bubble. After the bubble ex_ctl[2]=0, so stall deasserts and the dependent instruction is latched on the following edge.
- stall_count:
  - Increments by 1 on each posedge where stall=1 and rst_n=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unchanged on flush cycles.
- Simultaneous flush and hazard: flush wins, stall=0 so the PC can redirect, and the counter does not increment.
- Reset mid-stall: the next edge clears ex_ctl, and stall drops in the same cycle that reset is sampled (gated by rst_n).
- Bubble encoding: all-zero ex_ctl, guaranteeing no register or memory write downstream.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with if_id_instr=0xFFFFFFFF, ctl_in=0xFF -> all ex_* = 0, stall=0, stall_count=0.
2. Normal latch: instr 0x012A4020 (add $8,$9,$10), ctl_in=0x21, rf_data1=5, rf_data2=7 -> rs_addr=9, rt_addr=10; next edge ex_rs=9, ex_rt=10, ex_rd=8, ex_data1=5, ex_data2=7, ex_imm=0x00004020, ex_ctl=0x21.
3. Load-use: lw $8,-4($9) (0x8D28FFFC, ctl_in=0x17), then add $10,$8,$8 held in IF/ID:
   - ex_imm=0xFFFFFFFC after the lw edge.
   - stall=1 for exactly one cycle, followed by ex_ctl=0 (bubble).
   - The add is latched on the next edge; stall_count=1.
4. Bypass: rs=9, rf_data1=0x11, wb_reg_write=1, wb_w_reg=9, wb_data=0xDEADBEEF -> ex_data1=0xDEADBEEF. Repeat with wb_w_reg=0 and rs=0 -> ex_data1=rf_data1.
5. Flush during hazard: setup as in 3 with flush=1 in the hazard cycle -> stall=0, ex_ctl=0, stall_count unchanged.
6. Saturation (CNT_W=4 override): hold a hazard for 20 cycles -> stall_count reaches 15 and stays at 15.
